// File: rtl/ngy_grid_video_scanner.sv
// ngy_grid_video_scanner
//   Reads the grid_ram cell bit-vector and turns it into a pixel stream
//   (rgb/de/hs/vs) for the video scaler. grid_ram is copied into a shadow
//   register once per frame, at the last pixel slot, so the writer can never
//   tear a frame.
//   Optional build macro NGY_GRID_LINES_EN: draws a grey border on the first
//   pixel row and column of every cell. Timing does not change.
module ngy_grid_video_scanner #(
  parameter int          GRID_ROWS = 30,
  parameter int          GRID_COLS = 40,
  parameter int          CELL_PX   = 8,
  parameter int          CLK_DIV   = 12,
  parameter int          H_TOTAL   = 400,
  parameter int          V_TOTAL   = 258,
  parameter int          H_FP      = 8,
  parameter int          V_FP      = 4,
  parameter logic [23:0] ON_RGB    = 24'hFFFFFF,
  parameter logic [23:0] OFF_RGB   = 24'h000000
) (
  input  logic                             clk_74a,
  input  logic                             reset_n,
  input  logic [0:GRID_ROWS*GRID_COLS-1]   grid_ram,
  output logic                             pix_ce,
  output logic [23:0]                      video_rgb,
  output logic                             video_de,
  output logic                             video_hs,
  output logic                             video_vs,
  output logic                             frame_start
);

  localparam int N_CELLS  = GRID_ROWS * GRID_COLS;
  localparam int H_ACTIVE = GRID_COLS * CELL_PX;
  localparam int V_ACTIVE = GRID_ROWS * CELL_PX;
  localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int IW       = (N_CELLS > 1) ? $clog2(N_CELLS) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [HW-1:0] H_SYNC   = HW'(H_ACTIVE + H_FP);
  localparam logic [VW-1:0] V_SYNC   = VW'(V_ACTIVE + V_FP);
  localparam logic [23:0]   LINE_RGB = 24'h404040;

  logic [DW-1:0]        div_cnt;
  logic [HW-1:0]        h_cnt;
  logic [VW-1:0]        v_cnt;
  logic [0:N_CELLS-1]   shadow;

  logic                 ce;
  logic                 h_last;
  logic                 v_last;
  logic                 active;
  logic [31:0]          cell_row;
  logic [31:0]          cell_col;
  logic [IW-1:0]        cell_idx;
  logic [23:0]          pix_rgb;

  // Pixel slot decode, cell lookup and colour selection for the current counters
  always_comb begin
    ce       = (div_cnt == DIV_LAST);
    h_last   = (h_cnt == H_LAST);
    v_last   = (v_cnt == V_LAST);
    active   = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    // Generic divide: a power-of-two CELL_PX folds to a shift in synthesis
    cell_row = 32'(v_cnt) / CELL_PX;
    cell_col = 32'(h_cnt) / CELL_PX;
    cell_idx = IW'(cell_row * GRID_COLS + cell_col);
    pix_rgb  = 24'h000000;
    if (active) begin
      pix_rgb = shadow[cell_idx] ? ON_RGB : OFF_RGB;
`ifdef NGY_GRID_LINES_EN
      if ((32'(h_cnt) % CELL_PX == 0) || (32'(v_cnt) % CELL_PX == 0))
        pix_rgb = LINE_RGB;
`endif
    end
  end

  // Clock divider producing one pixel slot every CLK_DIV clocks
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n)
      div_cnt <= '0;
    else if (ce)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + DW'(1);
  end

  // Raster position, advanced once per pixel slot
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (ce) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + VW'(1);
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
    end
  end

  // Registered video outputs; they hold between pixel slots
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      pix_ce    <= 1'b0;
      video_rgb <= 24'h000000;
      video_de  <= 1'b0;
      video_hs  <= 1'b0;
      video_vs  <= 1'b0;
    end else begin
      pix_ce <= ce;
      if (ce) begin
        video_rgb <= pix_rgb;
        video_de  <= active;
        video_hs  <= (h_cnt == H_SYNC);
        video_vs  <= (v_cnt == V_SYNC) && (h_cnt == '0);
      end
    end
  end

  // Frame snapshot of grid_ram at the last slot so the next frame is coherent
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      shadow      <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (ce && h_last && v_last) begin
        shadow      <= grid_ram;
        frame_start <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ngy_grid_video_scanner.sv
// tb_ngy_grid_video_scanner
//   Directed bench on a 2x3 grid of 2x2-pixel cells, 10x7 pixel frame,
//   two clocks per pixel. Expected pixels come from the cell pattern the
//   bench knows each frame should show.
module tb_ngy_grid_video_scanner;

  logic        clk_74a = 1'b0;
  logic        reset_n = 1'b0;
  logic [0:5]  grid_ram = 6'b111111;
  logic        pix_ce;
  logic [23:0] video_rgb;
  logic        video_de;
  logic        video_hs;
  logic        video_vs;
  logic        frame_start;

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  int th = 0, tv = 0;
  int de_cnt = 0, hs_cnt = 0, vs_cnt = 0, fs_cnt = 0;
  int prev_fs = -1;
  int rel_cyc = 0;
  bit first_after_rst = 1'b0;
  bit frame_whole = 1'b1;
  logic [0:5] eg = 6'b000000;

  ngy_grid_video_scanner #(
    .GRID_ROWS(2), .GRID_COLS(3), .CELL_PX(2), .CLK_DIV(2),
    .H_TOTAL(10), .V_TOTAL(7), .H_FP(1), .V_FP(1),
    .ON_RGB(24'hFFFFFF), .OFF_RGB(24'h000000)
  ) dut (
    .clk_74a(clk_74a), .reset_n(reset_n), .grid_ram(grid_ram),
    .pix_ce(pix_ce), .video_rgb(video_rgb), .video_de(video_de),
    .video_hs(video_hs), .video_vs(video_vs), .frame_start(frame_start)
  );

  always #5 clk_74a = ~clk_74a;
  always @(posedge clk_74a) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_pix_ce"}, 32'(pix_ce), 0);
    chk({tag, "_rgb"}, 32'(video_rgb), 0);
    chk({tag, "_de"}, 32'(video_de), 0);
    chk({tag, "_hs"}, 32'(video_hs), 0);
    chk({tag, "_vs"}, 32'(video_vs), 0);
    chk({tag, "_fs"}, 32'(frame_start), 0);
  endtask

  task automatic restart_tracking();
    th = 0; tv = 0;
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0;
    prev_fs = -1;
    frame_whole = 1'b1;
  endtask

  task automatic process_pixel();
    logic [23:0] exp_rgb;
    bit act;
    int idx;
    if (first_after_rst) begin
      chk("first_ce_clk", 32'(cyc - rel_cyc), 2);
      first_after_rst = 1'b0;
    end
    act = (th < 6) && (tv < 4);
    exp_rgb = 24'h0;
    if (act) begin
      idx = (tv / 2) * 3 + (th / 2);
      exp_rgb = eg[idx] ? 24'hFFFFFF : 24'h000000;
`ifdef NGY_GRID_LINES_EN
      if ((th % 2 == 0) || (tv % 2 == 0)) exp_rgb = 24'h404040;
      if (th == 2 && tv == 0) chk("grid_line_2_0", 32'(video_rgb), 32'h404040);
`endif
    end
    chk($sformatf("rgb_%0d_%0d", th, tv), 32'(video_rgb), 32'(exp_rgb));
    chk($sformatf("de_%0d_%0d", th, tv), 32'(video_de), 32'(act));
    chk($sformatf("hs_%0d_%0d", th, tv), 32'(video_hs), 32'(th == 7));
    chk($sformatf("vs_%0d_%0d", th, tv), 32'(video_vs), 32'(tv == 5 && th == 0));
    if (video_de) de_cnt++;
    if (video_hs) hs_cnt++;
    if (video_vs) vs_cnt++;
    if (th == 9 && tv == 6) begin
      if (frame_whole) begin
        chk("frame_de_count", 32'(de_cnt), 24);
        chk("frame_hs_count", 32'(hs_cnt), 7);
        chk("frame_vs_count", 32'(vs_cnt), 1);
        chk("frame_fs_count", 32'(fs_cnt), 1);
      end
      de_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0;
      frame_whole = 1'b1;
      th = 0; tv = 0;
    end else if (th == 9) begin
      th = 0; tv++;
    end else begin
      th++;
    end
  endtask

  task automatic run_pixels(input int n);
    int waited;
    for (int p = 0; p < n; p++) begin
      waited = 0;
      do begin
        @(posedge clk_74a); #1;
        waited++;
        if (frame_start) begin
          fs_cnt++;
          if (prev_fs >= 0) chk("fs_period_clks", 32'(cyc - prev_fs), 140);
          prev_fs = cyc;
        end
      end while (!pix_ce && waited < 10);
      if (!pix_ce) begin
        chk("pix_ce_timeout", 32'(waited), 0);
        return;
      end
      process_pixel();
    end
  endtask

  initial begin
    reset_n = 1'b0;
    grid_ram = 6'b111111;
    repeat (5) @(posedge clk_74a);
    #1;
    chk_idle("reset");
    chk("reset_div_cnt", 32'(dut.div_cnt), 0);
    chk("reset_h_cnt", 32'(dut.h_cnt), 0);
    chk("reset_v_cnt", 32'(dut.v_cnt), 0);
    @(negedge clk_74a);
    reset_n = 1'b1;
    rel_cyc = cyc;
    first_after_rst = 1'b1;
    restart_tracking();

    // frame 1: shadow still clear
    eg = 6'b000000;
    run_pixels(35);
    grid_ram = 6'b100001;
    run_pixels(35);

    // frame 2: 100001 snapshot, mid-frame write must stay invisible
    eg = 6'b100001;
    run_pixels(35);
    grid_ram = 6'b010000;
    run_pixels(35);

    // frame 3: partial, then reset mid-frame
    eg = 6'b010000;
    run_pixels(30);
    reset_n = 1'b0;
    #1;
    chk_idle("midreset");
    repeat (3) @(posedge clk_74a);
    @(negedge clk_74a);
    reset_n = 1'b1;
    rel_cyc = cyc;
    first_after_rst = 1'b1;
    restart_tracking();

    // frame after reset: shadow cleared again
    eg = 6'b000000;
    run_pixels(70);
    // then a normal frame from the snapshot
    eg = 6'b010000;
    run_pixels(70);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
